// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, tx state encodings and a small helper
package uart_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    START = ST_START,
    DATA = ST_DATA,
    STOP = ST_STOP
  } tx_state_e;
  localparam int OS_TICK = 16;
  localparam int N_BITS_DEF = 8;
  localparam int N_COUNT = 163;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/uart_tx.sv
// uart_tx: tick-paced UART transmitter, 1 start bit, N_BITS data LSB first, stop
//   clock        system clock
//   reset        synchronous active-high reset
//   tick         oversampling strobe from the shared baud generator
//   tx_start     send request, sampled only in IDLE
//   din          word to send, captured on acceptance
//   tx           registered serial line, idle high
//   tx_busy      high from the cycle after acceptance until back in IDLE
//   tx_done_tick one-clock pulse in the first IDLE cycle after the stop bit
module uart_tx #(
  parameter int N_BITS = uart_pkg::N_BITS_DEF,
  parameter int SB_TICK = 16,
  parameter int OS_TICK = uart_pkg::OS_TICK
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              tx_start,
  input  logic [N_BITS-1:0] din,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done_tick
);
  import uart_pkg::*;
  localparam int SW = $clog2(max2(OS_TICK, SB_TICK));
  localparam int NW = N_BITS > 1 ? $clog2(N_BITS) : 1;
  tx_state_e         state_q, state_d;
  logic [SW-1:0]     s_cnt_q, s_cnt_d;
  logic [NW-1:0]     n_cnt_q, n_cnt_d;
  logic [N_BITS-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d, busy_q, done_q, done_d;
  logic              os_end, sb_end;
  assign os_end = tick && s_cnt_q == SW'(OS_TICK - 1);
  assign sb_end = tick && s_cnt_q == SW'(SB_TICK - 1);
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    done_d = 1'b0;
    case (state_q)
      IDLE:
        if (tx_start) begin
          shreg_d = din;
          s_cnt_d = '0;
          state_d = START;
        end
      START:
        if (tick) begin
          s_cnt_d = os_end ? '0 : s_cnt_q + 1'b1;
          if (os_end) begin
            n_cnt_d = '0;
            state_d = DATA;
          end
        end
      DATA:
        if (tick) begin
          s_cnt_d = os_end ? '0 : s_cnt_q + 1'b1;
          if (os_end) begin
            shreg_d = shreg_q >> 1;
            n_cnt_d = n_cnt_q == NW'(N_BITS - 1) ? n_cnt_q : n_cnt_q + 1'b1;
            state_d = n_cnt_q == NW'(N_BITS - 1) ? STOP : DATA;
          end
        end
      STOP:
        if (tick) begin
          s_cnt_d = sb_end ? '0 : s_cnt_q + 1'b1;
          state_d = sb_end ? IDLE : STOP;
          done_d = sb_end;
        end
      default: state_d = IDLE;
    endcase
  end
  // line decoded from the next state so it moves with the state register
  assign tx_d = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : 1'b1;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      tx_q <= tx_d;
      busy_q <= state_d != IDLE;
      done_q <= done_d;
    end
  end
  assign tx = tx_q;
  assign tx_busy = busy_q;
  assign tx_done_tick = done_q;
endmodule
